r_exec_unit: RTL and testbench
==============================

Name: r_exec_unit

Overview:
- Execute/write-back stage directly downstream of the instruction fetch/decode stage.
- Consumes the decoded R-type fields (op_code, rs, rt, rd, shamt, func) and owns the 32x32-bit register file.
- Runs a multi-cycle read/execute/write-back sequence and produces result flags.
- Provides a load port so test code can preset registers.

Parameters:
- DW, 32, datapath and register width.
- NREG, 32, register count; address width fixed at 5.

Ports:
- clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  decoded instruction fields are valid.
- inst_ready  out  1  block can accept an instruction (high only in IDLE).
- op_code  in  6  opcode field.
- rs_addr  in  5  source register 1.
- rt_addr  in  5  source register 2.
- rd_addr  in  5  destination register.
- shamt  in  5  shift amount.
- func  in  6  function field.
- ld_en  in  1  register preload strobe.
- ld_addr  in  5  preload address.
- ld_data  in  32  preload data.
- dbg_addr  in  5  combinational debug read address.
- dbg_data  out  32  register[dbg_addr]; always 0 for address 0.
- wb_valid  out  1  one-cycle pulse when write-back state completes.
- wb_addr  out  5  destination written (0 if write suppressed).
- wb_data  out  32  ALU result.
- ZF  out  1  result == 0.
- OF  out  1  signed overflow (add/sub only).
- ill  out  1  illegal/unsupported instruction.

Behaviour:
- Reset (Reset_n low, async): state=IDLE; all registers 0; wb_valid=0, wb_addr=0, wb_data=0, ZF=0, OF=0, ill=0; inst_ready=1 once reset is released.
- FSM states and transitions:
  - IDLE: inst_ready=1. On inst_valid=1, capture all fields, go to READ. If ld_en=1 and inst_valid=0, write ld_data to reg[ld_addr]. If both are high, the instruction wins and the load is dropped. ld_en is ignored outside IDLE.
  - READ: latch A=reg[rs], B=reg[rt]; go to EXEC.
  - EXEC: compute result, ZF, OF and ill; register them; go to WB.
  - WB: if write is allowed, reg[rd]=result. Pulse wb_valid for exactly this cycle. Return to IDLE.
- Latency: accept edge + 3 clocks to wb_valid; next accept possible the cycle after WB, so throughput is 1 instruction per 4 clocks.
- Supported instructions (op_code=000000), by func:
  - 100000 add; 100001 addu; 100010 sub; 100011 subu.
  - 100100 and; 100101 or; 100110 xor; 100111 nor.
  - 101010 slt (signed); 101011 sltu.
  - 000000 sll B<<shamt; 000010 srl; 000011 sra (arithmetic).
  - 000100 sllv; 000110 srlv; 000111 srav, all using A[4:0] as the shift amount.
- Width rules:
  - Arithmetic is 32-bit modulo.
  - OF = (A and B sign equal for add, or differ for sub) and result sign differs from A.
  - OF is forced to 0 for addu/subu and all other ops.
- Write is suppressed (wb_addr=0) when any of:
  - rd=0; register 0 is always 0 and never written.
  - OF=1 on add/sub; wb_data still shows the wrapped sum.
  - ill=1.
- Illegal instructions: op_code≠0 or unlisted func sets ill=1 and result=0. ZF follows result, so ZF=1.
- Flags (ZF/OF/ill/wb_data) hold their values until the next EXEC.
- Register reads in READ see any write made in the previous WB (no hazard, sequential).
- Reset asserted mid-operation aborts immediately; no partial write occurs.

Decomposition:
- Shared package: func and op_code constants, FSM state encoding, ALU-op enum.
- One natural sub-module: r_alu, a combinational ALU taking A, B, shamt and func and producing result, OF and ill.
- The register file stays inline.

Test Plan:
- Preload r1=7, r2=5 via ld_en; add rd=3 -> wb_valid 3 clocks after accept; wb_addr=3, wb_data=12, ZF=0, OF=0; dbg_data(3)=12.
- r1=0x7FFFFFFF, r2=1, add rd=4 -> OF=1, wb_data=0x80000000, wb_addr=0, r4 unchanged; same operands with addu -> r4=0x80000000, OF=0.
- r1=0x80000000: sra shamt=4 rt=1 -> 0xF8000000; srl -> 0x08000000; slt r1<r2(=1) -> 1; sltu -> 0.
- sub rd=0 with r1=r2=9 -> ZF=1, wb_addr=0, dbg_data(0)=0; then op_code=001000 -> ill=1, no register changes.
- inst_valid held high continuously -> inst_ready low for 3 cycles per instruction, exactly one wb_valid per 4 clocks; ld_en raised during READ is ignored.
- Reset_n pulled low during EXEC -> all outputs 0 and registers 0 immediately; after release, inst_ready=1 and a subsequent add of r0+r0 gives ZF=1.

Source files
------------

// File: rtl/r_exec_unit_pkg.sv
// Shared definitions for the R-type execute/write-back stage:
// field constants, FSM encoding, ALU operation decode.
package r_exec_unit_pkg;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
    ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLLV, ALU_SRLV, ALU_SRAV,
    ALU_ILL
  } alu_op_e;

  // Captured instruction fields
  typedef struct packed {
    logic [5:0]    op;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [4:0]    shamt;
    logic [5:0]    fn;
  } inst_t;

  // Map op_code/func to an ALU operation; anything unlisted is illegal
  function automatic alu_op_e alu_decode(input logic [5:0] op, input logic [5:0] fn);
    alu_op_e r;
    r = ALU_ILL;
    if (op == OP_RTYPE) begin
      case (fn)
        F_ADD:   r = ALU_ADD;
        F_ADDU:  r = ALU_ADDU;
        F_SUB:   r = ALU_SUB;
        F_SUBU:  r = ALU_SUBU;
        F_AND:   r = ALU_AND;
        F_OR:    r = ALU_OR;
        F_XOR:   r = ALU_XOR;
        F_NOR:   r = ALU_NOR;
        F_SLT:   r = ALU_SLT;
        F_SLTU:  r = ALU_SLTU;
        F_SLL:   r = ALU_SLL;
        F_SRL:   r = ALU_SRL;
        F_SRA:   r = ALU_SRA;
        F_SLLV:  r = ALU_SLLV;
        F_SRLV:  r = ALU_SRLV;
        F_SRAV:  r = ALU_SRAV;
        default: r = ALU_ILL;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/r_exec_unit_if.sv
// Instruction, preload, debug and write-back signals of r_exec_unit.
interface r_exec_unit_if #(parameter int DW = 32);
  logic          inst_valid;
  logic          inst_ready;
  logic [5:0]    op_code;
  logic [4:0]    rs_addr;
  logic [4:0]    rt_addr;
  logic [4:0]    rd_addr;
  logic [4:0]    shamt;
  logic [5:0]    func;
  logic          ld_en;
  logic [4:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic [4:0]    dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          wb_valid;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          ZF;
  logic          OF;
  logic          ill;

  modport master (
    output inst_valid, op_code, rs_addr, rt_addr, rd_addr, shamt, func,
           ld_en, ld_addr, ld_data, dbg_addr,
    input  inst_ready, dbg_data, wb_valid, wb_addr, wb_data, ZF, OF, ill
  );

  modport slave (
    input  inst_valid, op_code, rs_addr, rt_addr, rd_addr, shamt, func,
           ld_en, ld_addr, ld_data, dbg_addr,
    output inst_ready, dbg_data, wb_valid, wb_addr, wb_data, ZF, OF, ill
  );
endinterface

// File: rtl/r_exec_unit_alu.sv
// Combinational R-type ALU: result, signed overflow (add/sub) and illegal flag.
module r_alu
  import r_exec_unit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [4:0]    i_shamt,
  input  logic [5:0]    i_op_code,
  input  logic [5:0]    i_func,
  output logic [DW-1:0] o_result,
  output logic          o_of,
  output logic          o_ill
);

  alu_op_e       w_op;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic [4:0]    w_vsh;

  assign w_op   = alu_decode(i_op_code, i_func);
  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_vsh  = i_a[4:0];

  // Operation select; illegal ops leave result at zero
  always_comb begin
    o_result = '0;
    o_of     = 1'b0;
    o_ill    = 1'b0;
    case (w_op)
      ALU_ADD: begin
        o_result = w_sum;
        o_of     = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
      end
      ALU_ADDU: o_result = w_sum;
      ALU_SUB: begin
        o_result = w_diff;
        o_of     = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);
      end
      ALU_SUBU: o_result = w_diff;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {{(DW-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(DW-1){1'b0}}, (i_a < i_b)};
      ALU_SLL:  o_result = i_b << i_shamt;
      ALU_SRL:  o_result = i_b >> i_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_b) >>> i_shamt);
      ALU_SLLV: o_result = i_b << w_vsh;
      ALU_SRLV: o_result = i_b >> w_vsh;
      ALU_SRAV: o_result = $unsigned($signed(i_b) >>> w_vsh);
      default:  o_ill    = 1'b1;
    endcase
  end

endmodule

// File: rtl/r_exec_unit.sv
// R-type execute/write-back stage: IDLE -> READ -> EXEC -> WB, one
// instruction per four clocks, with an inline 32-entry register file.
module r_exec_unit
  import r_exec_unit_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         Reset_n,
  r_exec_unit_if.slave bus
);

  state_e        r_state;
  state_e        w_state_nxt;
  inst_t         r_inst;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_result;
  logic          r_zf;
  logic          r_of;
  logic          r_ill;
  logic [AW-1:0] r_wb_addr;
  logic [DW-1:0] r_rf [NREG];

  logic [DW-1:0] w_alu_res;
  logic          w_alu_of;
  logic          w_alu_ill;
  logic          w_capture;
  logic          w_ld_we;
  logic          w_wb_we;
  logic          w_ready;
  logic          w_wb_valid;

  r_alu #(.DW(DW)) u_alu (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_shamt   (r_inst.shamt),
    .i_op_code (r_inst.op),
    .i_func    (r_inst.fn),
    .o_result  (w_alu_res),
    .o_of      (w_alu_of),
    .o_ill     (w_alu_ill)
  );

  // Next state and per-state strobes; an instruction beats a same-cycle preload
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_ld_we     = 1'b0;
    w_wb_we     = 1'b0;
    w_ready     = 1'b0;
    w_wb_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.inst_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_READ;
        end else if (bus.ld_en && (bus.ld_addr != '0)) begin
          w_ld_we = 1'b1;
        end
      end
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB: begin
        w_wb_valid  = 1'b1;
        w_wb_we     = (r_wb_addr != '0);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Capture decoded fields on accept
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) r_inst <= '0;
    else if (w_capture)
      r_inst <= '{op: bus.op_code, rs: bus.rs_addr, rt: bus.rt_addr,
                  rd: bus.rd_addr, shamt: bus.shamt, fn: bus.func};
  end

  // Operand latch; a WB write from the previous cycle is already in the file
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (r_state == ST_READ) begin
      r_a <= r_rf[r_inst.rs];
      r_b <= r_rf[r_inst.rt];
    end
  end

  // Result/flag registers; they hold until the next EXEC.
  // Destination is zeroed when the write is suppressed (r0, add/sub overflow, illegal).
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_result  <= '0;
      r_zf      <= 1'b0;
      r_of      <= 1'b0;
      r_ill     <= 1'b0;
      r_wb_addr <= '0;
    end else if (r_state == ST_EXEC) begin
      r_result  <= w_alu_res;
      r_zf      <= (w_alu_res == '0);
      r_of      <= w_alu_of;
      r_ill     <= w_alu_ill;
      r_wb_addr <= (w_alu_of || w_alu_ill) ? '0 : r_inst.rd;
    end
  end

  // Register file: preload in IDLE or write-back in WB; r0 is never written
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_ld_we) begin
      r_rf[bus.ld_addr] <= bus.ld_data;
    end else if (w_wb_we) begin
      r_rf[r_wb_addr] <= r_result;
    end
  end

  assign bus.inst_ready = w_ready && Reset_n;
  assign bus.wb_valid   = w_wb_valid;
  assign bus.wb_addr    = r_wb_addr;
  assign bus.wb_data    = r_result;
  assign bus.ZF         = r_zf;
  assign bus.OF         = r_of;
  assign bus.ill        = r_ill;
  assign bus.dbg_data   = (bus.dbg_addr == '0) ? '0 : r_rf[bus.dbg_addr];

endmodule

// File: tb/tb_r_exec_unit.sv
// Bench for r_exec_unit: vector table issued one by one, write-back results
// checked by a scoreboard monitor, plus back-to-back and mid-op reset sequences.
module tb_r_exec_unit;
  import r_exec_unit_pkg::*;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;

  r_exec_unit_if #(.DW(32)) u_if ();

  r_exec_unit #(.DW(32), .NREG(32)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        zf, of, ill;
    logic [4:0]  da;
    logic [31:0] dv;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        zf, of, ill;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input int op, input int rs, input int rt, input int rd,
                              input int sh, input logic [5:0] fn, input logic [31:0] data,
                              input int addr, input int zf, input int of, input int ill,
                              input int da, input logic [31:0] dv);
    vec_t v;
    v.op = 6'(op); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.sh = 5'(sh);
    v.fn = fn; v.data = data; v.addr = 5'(addr);
    v.zf = 1'(zf); v.of = 1'(of); v.ill = 1'(ill);
    v.da = 5'(da); v.dv = dv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every write-back pulse pops one expected record
  always @(negedge clk) begin
    if (Reset_n && u_if.wb_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: wb_valid with nothing pending, wb_addr %0d expected none",
                 u_if.wb_addr);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("i%0d wb_data", mon_e.id), u_if.wb_data, mon_e.data);
        chk($sformatf("i%0d wb_addr", mon_e.id), 32'(u_if.wb_addr), 32'(mon_e.addr));
        chk($sformatf("i%0d ZF", mon_e.id),  32'(u_if.ZF),  32'(mon_e.zf));
        chk($sformatf("i%0d OF", mon_e.id),  32'(u_if.OF),  32'(mon_e.of));
        chk($sformatf("i%0d ill", mon_e.id), 32'(u_if.ill), 32'(mon_e.ill));
      end
    end
  end

  task automatic load(input int a, input logic [31:0] d);
    @(negedge clk);
    u_if.ld_en = 1'b1; u_if.ld_addr = 5'(a); u_if.ld_data = d;
    @(posedge clk);
    #1 u_if.ld_en = 1'b0;
  endtask

  task automatic dbg(input string nm, input int a, input logic [31:0] exp);
    u_if.dbg_addr = 5'(a);
    #1 chk(nm, u_if.dbg_data, exp);
  endtask

  // Issue one instruction, check accept/latency, then read back one register
  task automatic issue(input vec_t v, input int id);
    int   cyc;
    exp_t e;
    cyc = 0;
    @(negedge clk);
    while (!u_if.inst_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("i%0d inst_ready", id), 32'(u_if.inst_ready), 32'd1);
    u_if.op_code = v.op; u_if.rs_addr = v.rs; u_if.rt_addr = v.rt;
    u_if.rd_addr = v.rd; u_if.shamt = v.sh; u_if.func = v.fn;
    u_if.inst_valid = 1'b1;
    e = '{id, v.data, v.addr, v.zf, v.of, v.ill};
    @(posedge clk);
    #1 u_if.inst_valid = 1'b0;
    sb.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!u_if.wb_valid && cyc < 8);
    chk($sformatf("i%0d latency", id), 32'(cyc), 32'd3);
    @(posedge clk);
    #1 dbg($sformatf("i%0d dbg r%0d", id, v.da), int'(v.da), v.dv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low, n_wb;
    u_if.inst_valid = 1'b0; u_if.op_code = '0; u_if.rs_addr = '0; u_if.rt_addr = '0;
    u_if.rd_addr = '0; u_if.shamt = '0; u_if.func = '0; u_if.ld_en = 1'b0;
    u_if.ld_addr = '0; u_if.ld_data = '0; u_if.dbg_addr = '0;

    vecs[0]  = mk(0, 1, 2, 3, 0, F_ADD,  32'd12,        3, 0, 0, 0,  3, 32'd12);
    vecs[1]  = mk(0, 5, 6, 4, 0, F_ADD,  32'h8000_0000, 0, 0, 1, 0,  4, 32'd0);
    vecs[2]  = mk(0, 5, 6, 4, 0, F_ADDU, 32'h8000_0000, 4, 0, 0, 0,  4, 32'h8000_0000);
    vecs[3]  = mk(0, 0, 7, 12, 4, F_SRA, 32'hF800_0000, 12, 0, 0, 0, 12, 32'hF800_0000);
    vecs[4]  = mk(0, 0, 7, 13, 4, F_SRL, 32'h0800_0000, 13, 0, 0, 0, 13, 32'h0800_0000);
    vecs[5]  = mk(0, 7, 1, 14, 0, F_SLT,  32'd1,        14, 0, 0, 0, 14, 32'd1);
    vecs[6]  = mk(0, 7, 1, 15, 0, F_SLTU, 32'd0,        15, 1, 0, 0, 15, 32'd0);
    vecs[7]  = mk(0, 8, 9, 0, 0, F_SUB,  32'd0,         0, 1, 0, 0,  0, 32'd0);
    vecs[8]  = mk(8, 1, 2, 16, 0, F_ADD, 32'd0,         0, 1, 0, 1, 16, 32'd0);
    vecs[9]  = mk(0, 7, 6, 17, 0, F_SUB, 32'h7FFF_FFFF, 0, 0, 1, 0, 17, 32'd0);
    vecs[10] = mk(0, 7, 6, 17, 0, F_SUBU, 32'h7FFF_FFFF, 17, 0, 0, 0, 17, 32'h7FFF_FFFF);
    vecs[11] = mk(0, 10, 1, 18, 0, F_AND, 32'd0,        18, 1, 0, 0, 18, 32'd0);
    vecs[12] = mk(0, 10, 1, 19, 0, F_OR,  32'hFFFF_FFF7, 19, 0, 0, 0, 19, 32'hFFFF_FFF7);
    vecs[13] = mk(0, 1, 2, 20, 0, F_XOR,  32'd2,        20, 0, 0, 0, 20, 32'd2);
    vecs[14] = mk(0, 1, 2, 21, 0, F_NOR,  32'hFFFF_FFF8, 21, 0, 0, 0, 21, 32'hFFFF_FFF8);
    vecs[15] = mk(0, 0, 2, 22, 3, F_SLL,  32'h28,       22, 0, 0, 0, 22, 32'h28);
    vecs[16] = mk(0, 11, 1, 23, 0, F_SLLV, 32'h38,      23, 0, 0, 0, 23, 32'h38);
    vecs[17] = mk(0, 11, 10, 24, 0, F_SRLV, 32'h1FFF_FFFE, 24, 0, 0, 0, 24, 32'h1FFF_FFFE);
    vecs[18] = mk(0, 11, 10, 25, 0, F_SRAV, 32'hFFFF_FFFE, 25, 0, 0, 0, 25, 32'hFFFF_FFFE);
    vecs[19] = mk(0, 1, 2, 26, 0, 6'b001111, 32'd0,     0, 1, 0, 1, 26, 32'd0);
    vecs[20] = mk(0, 3, 1, 27, 0, F_ADD,  32'd19,       27, 0, 0, 0, 27, 32'd19);
    vecs[21] = mk(0, 2, 1, 28, 0, F_SUB,  32'hFFFF_FFFE, 28, 0, 0, 0, 28, 32'hFFFF_FFFE);
    vecs[22] = mk(0, 10, 10, 29, 0, F_ADD, 32'hFFFF_FFE0, 29, 0, 0, 0, 29, 32'hFFFF_FFE0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst wb_valid", 32'(u_if.wb_valid), 32'd0);
    chk("rst wb_addr",  32'(u_if.wb_addr),  32'd0);
    chk("rst wb_data",  u_if.wb_data,       32'd0);
    chk("rst ZF",  32'(u_if.ZF),  32'd0);
    chk("rst OF",  32'(u_if.OF),  32'd0);
    chk("rst ill", 32'(u_if.ill), 32'd0);
    @(negedge clk);
    Reset_n = 1'b1;
    #1 chk("rst inst_ready", 32'(u_if.inst_ready), 32'd1);

    load(1, 32'd7);          load(2, 32'd5);
    load(5, 32'h7FFF_FFFF);  load(6, 32'd1);
    load(7, 32'h8000_0000);  load(8, 32'd9);
    load(9, 32'd9);          load(10, 32'hFFFF_FFF0);
    load(11, 32'd3);
    dbg("ld r1", 1, 32'd7);
    dbg("ld r10", 10, 32'hFFFF_FFF0);

    for (int i = 0; i < NV; i++) issue(vecs[i], i);
    dbg("post ill r16", 16, 32'd0);
    dbg("post r4", 4, 32'h8000_0000);

    // inst_valid held high; ld_en held high from the accept cycle onward
    @(negedge clk);
    u_if.op_code = OP_RTYPE; u_if.rs_addr = 5'd1; u_if.rt_addr = 5'd2;
    u_if.rd_addr = 5'd30; u_if.shamt = '0; u_if.func = F_ADD;
    u_if.inst_valid = 1'b1;
    u_if.ld_en = 1'b1; u_if.ld_addr = 5'd31; u_if.ld_data = 32'hDEAD_BEEF;
    sb.push_back('{100, 32'd12, 5'd30, 1'b0, 1'b0, 1'b0});
    n_low = 0;
    n_wb  = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (!u_if.inst_ready) n_low++;
      else sb.push_back('{100 + i, 32'd12, 5'd30, 1'b0, 1'b0, 1'b0});
      if (u_if.wb_valid) n_wb++;
    end
    u_if.inst_valid = 1'b0;
    u_if.ld_en = 1'b0;
    chk("b2b ready_low_cycles", 32'(n_low), 32'd9);
    chk("b2b wb_pulses", 32'(n_wb), 32'd3);
    @(posedge clk);
    #1 dbg("b2b ld ignored r31", 31, 32'd0);
    dbg("b2b r30", 30, 32'd12);

    // Reset asserted while in EXEC: no write to r9, everything clears
    @(negedge clk);
    u_if.rs_addr = 5'd1; u_if.rt_addr = 5'd2; u_if.rd_addr = 5'd9; u_if.func = F_ADD;
    u_if.inst_valid = 1'b1;
    @(posedge clk);
    #1 u_if.inst_valid = 1'b0;
    @(posedge clk);
    #1 Reset_n = 1'b0;
    #1;
    chk("abort wb_valid", 32'(u_if.wb_valid), 32'd0);
    chk("abort wb_addr",  32'(u_if.wb_addr),  32'd0);
    chk("abort wb_data",  u_if.wb_data,       32'd0);
    chk("abort ZF",  32'(u_if.ZF),  32'd0);
    chk("abort OF",  32'(u_if.OF),  32'd0);
    chk("abort ill", 32'(u_if.ill), 32'd0);
    dbg("abort r1", 1, 32'd0);
    dbg("abort r9", 9, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    #1 chk("abort inst_ready", 32'(u_if.inst_ready), 32'd1);
    issue(mk(0, 0, 0, 1, 0, F_ADD, 32'd0, 1, 1, 0, 0, 9, 32'd0), 200);

    repeat (4) @(negedge clk);
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
